data_mem_arbiter: RTL

Arbiter and sequencer that shares the single-port DataMemory between two requesters: port 0 (core load/store) and port 1 (DMA/debug loader). It accepts one request at a time over valid/ready handshakes, drives the memory's address/MemRead/MemWrite/writeData strobes for exactly one cycle per access, and returns a registered response to the issuing port. It sits between the requesters and the DataMemory instance, which becomes its only owner.

---
 rtl/data_mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port DataMemory between port 0 (core) and
// port 1 (DMA/debug loader). One request in flight at a time, sequenced as
// IDLE -> ACCESS (one strobe cycle) -> RESP (held until the owner consumes it).
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise port 0 always
// wins a tie.
module data_mem_arbiter #(
    parameter int unsigned DEPTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0Valid,
    output logic        req0Ready,
    input  logic        req0Write,
    input  logic [31:0] req0Address,
    input  logic [31:0] req0WriteData,
    input  logic        req1Valid,
    output logic        req1Ready,
    input  logic        req1Write,
    input  logic [31:0] req1Address,
    input  logic [31:0] req1WriteData,
    output logic        rsp0Valid,
    input  logic        rsp0Ready,
    output logic [31:0] rsp0ReadData,
    output logic        rsp0Error,
    output logic        rsp1Valid,
    input  logic        rsp1Ready,
    output logic [31:0] rsp1ReadData,
    output logic        rsp1Error,
    output logic [31:0] address,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        winner;
    logic        grant;
    logic        mem_active;
    logic        in_resp;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_q;

    // Priority pointer flips to the other port after every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (grant) begin
            prio_q <= ~winner;
        end
    end
`endif

    // Pick the winning port; only meaningful when some request is valid.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        winner = (req0Valid && req1Valid) ? prio_q : req1Valid;
`else
        winner = ~req0Valid;
`endif
    end

    // Grant only in IDLE; rst_n keeps ready low while reset is held.
    assign grant     = rst_n && (state_q == StIdle) && (req0Valid || req1Valid);
    assign req0Ready = grant && !winner;
    assign req1Ready = grant && winner;

    // State and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: latch on handshake, capture read data in ACCESS.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        err_d   = err_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    owner_d = winner;
                    wr_d    = winner ? req1Write : req0Write;
                    addr_d  = winner ? req1Address : req0Address;
                    wdata_d = winner ? req1WriteData : req0WriteData;
                    err_d   = (winner ? req1Address : req0Address) >= DEPTH;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                rdata_d = (!wr_q && !err_q) ? readData : 32'h0;
                state_d = StResp;
            end
            StResp: begin
                if (owner_q ? rsp1Ready : rsp0Ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory strobes exist only in ACCESS and only for in-range addresses.
    always_comb begin
        mem_active = (state_q == StAccess) && !err_q;
        address    = mem_active ? addr_q : 32'h0;
        writeData  = mem_active ? wdata_q : 32'h0;
        MemRead    = mem_active && !wr_q;
        MemWrite   = mem_active && wr_q;
    end

    // Response outputs are driven for the owning port only.
    always_comb begin
        in_resp      = (state_q == StResp);
        rsp0Valid    = in_resp && !owner_q;
        rsp1Valid    = in_resp && owner_q;
        rsp0ReadData = rsp0Valid ? rdata_q : 32'h0;
        rsp1ReadData = rsp1Valid ? rdata_q : 32'h0;
        rsp0Error    = rsp0Valid && err_q;
        rsp1Error    = rsp1Valid && err_q;
    end

endmodule
